// File: rtl/switch_debouncer_if.sv
// Switch-side bundle of the debouncer: raw levels in, debounced levels and edge strobes out.
// The debouncer uses the slave modport; whatever drives the switches uses master.
interface switch_debouncer_if #(
    parameter int unsigned CHANNELS = 2
);
    logic [CHANNELS-1:0] sw_in;
    logic [CHANNELS-1:0] sw_clean;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;

    modport master (
        output sw_in,
        input  sw_clean,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  sw_in,
        output sw_clean,
        output rise_pulse,
        output fall_pulse
    );
endinterface

// File: rtl/switch_debouncer.sv
// Multi-channel slide-switch debouncer: a two-flop synchronizer, then a per-channel
// four-state FSM with a saturating stability counter. All outputs are registered.
module switch_debouncer #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned STABLE_CYCLES = 500000
) (
    input logic               clk,
    input logic               reset,
    switch_debouncer_if.slave bus
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntLast = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StableLo,
        PendHi,
        StableHi,
        PendLo
    } state_t;

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sw_sync;
    logic [CHANNELS-1:0] clean;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sw_sync <= '0;
        end else begin
            sync1_q <= bus.sw_in;
            sw_sync <= sync1_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          clean_q, clean_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            clean_d = clean_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            unique case (state_q)
                StableLo: begin
                    if (sw_sync[i]) begin
                        // A single stable sample is enough: commit without a pending state.
                        if (STABLE_CYCLES == 1) begin
                            state_d = StableHi;
                            clean_d = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = PendHi;
                            cnt_d   = CntOne;
                        end
                    end
                end
                PendHi: begin
                    if (!sw_sync[i]) begin
                        state_d = StableLo;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StableHi;
                        cnt_d   = '0;
                        clean_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StableHi: begin
                    if (!sw_sync[i]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d = StableLo;
                            clean_d = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = PendLo;
                            cnt_d   = CntOne;
                        end
                    end
                end
                PendLo: begin
                    if (sw_sync[i]) begin
                        state_d = StableHi;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StableLo;
                        cnt_d   = '0;
                        clean_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StableLo;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= StableLo;
                cnt_q   <= '0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign clean[i] = clean_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

    assign bus.sw_clean   = clean;
    assign bus.rise_pulse = rise;
    assign bus.fall_pulse = fall;

endmodule
